// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end.
// Issues one memory read per cycle at the PC address while credit allows.
// Credit means in-flight reads plus buffered words stay below DEPTH.
// Read addresses are queued until their data returns, and returned words are
// buffered in a small FIFO that feeds the decoder.
// Optional feature macro: FETCH_PARITY_EN. When defined, a per-entry parity
// error flag is stored for every buffered word.
//
// Decoder handshake: a word transfers on any rising edge where instr_valid
// and instr_ready are both high. instr_valid depends only on internal state,
// never on instr_ready. While instr_valid is high and instr_ready is low, the
// head word, address and parity flag are held unchanged. instr_ready is
// ignored while instr_valid is low.
module fetch_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_enable,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  flush,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [14:0]           instr_word,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_parity_err
);

  // Pointer width and counter width. Counters must be able to hold DEPTH itself.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Occupancy and tracking counters
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] inflight, inflight_n;
  logic [CW-1:0] drop, drop_n;

  // Buffered-word FIFO pointers and in-flight address queue pointers
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] aq_wr, aq_rd;

  // Storage: buffered words with their addresses, and addresses of in-flight reads
  logic [14:0]           data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] aq_mem   [DEPTH];

`ifdef FETCH_PARITY_EN
  logic par_mem [DEPTH];
`else
  // Bit 15 carries parity, which this build does not check.
  logic unused_parity_bit;
  assign unused_parity_bit = mem_rdata[WORD_WIDTH-1];
`endif

  // Per-cycle events
  logic [CW:0] credit_sum;
  logic        issue;
  logic        resp;
  logic        push;
  logic        pop;

  // Credit check: every in-flight read already owns a FIFO slot.
  // So a full FIFO can never be pushed.
  assign credit_sum = {1'b0, inflight} + {1'b0, count};
  assign issue      = !reset && !flush && (credit_sum < (CW+1)'(DEPTH));

  assign pc_enable  = issue;
  assign mem_req    = issue;
  assign mem_addr   = pc_addr;

  // A response with nothing in flight is a protocol error.
  // It is ignored so that no counter can wrap below zero.
  assign resp = mem_rvalid && (inflight != '0);
  // A response is buffered only when it is not owed to an earlier flush.
  assign push = resp && (drop == '0) && !flush;
  assign pop  = (count != '0) && instr_ready && !flush;

  // Decoder-side outputs: head of FIFO, forced to zero when empty
  always_comb begin
    instr_valid      = (count != '0);
    instr_word       = '0;
    instr_addr       = '0;
    instr_parity_err = 1'b0;
    if (count != '0) begin
      instr_word = data_mem[rd_ptr];
      instr_addr = addr_mem[rd_ptr];
`ifdef FETCH_PARITY_EN
      instr_parity_err = par_mem[rd_ptr];
`endif
    end
  end

  // Next-state computation for the occupancy, in-flight and discard counters
  always_comb begin
    inflight_n = inflight;
    drop_n     = drop;
    count_n    = count;

    if (issue && !resp) begin
      inflight_n = inflight + CW'(1);
    end else if (!issue && resp) begin
      inflight_n = inflight - CW'(1);
    end

    // On flush, every read still outstanding after this edge must be discarded.
    // A response arriving on the flush edge is already discarded here.
    if (flush) begin
      drop_n = resp ? (inflight - CW'(1)) : inflight;
    end else if (resp && (drop != '0)) begin
      drop_n = drop - CW'(1);
    end

    if (flush) begin
      count_n = '0;
    end else if (push && !pop) begin
      count_n = count + CW'(1);
    end else if (!push && pop) begin
      count_n = count - CW'(1);
    end
  end

  // Control state register: counters and all pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      aq_wr    <= '0;
      aq_rd    <= '0;
    end else begin
      count    <= count_n;
      inflight <= inflight_n;
      drop     <= drop_n;

      // The address queue tracks reads, not buffered words.
      // A flush therefore leaves it alone.
      if (issue) begin
        aq_wr <= aq_wr + PW'(1);
      end
      if (resp) begin
        aq_rd <= aq_rd + PW'(1);
      end

      // A flush empties the FIFO.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Data-path storage writes. Contents are only read under a valid count.
  always_ff @(posedge clk) begin
    if (issue) begin
      aq_mem[aq_wr] <= pc_addr;
    end
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata[14:0];
      addr_mem[wr_ptr] <= aq_mem[aq_rd];
`ifdef FETCH_PARITY_EN
      // AGC words carry odd parity, so an even-parity word is flagged.
      par_mem[wr_ptr]  <= ~^mem_rdata[15:0];
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The bench owns a PC model and a fixed-latency, in-order memory model.
module tb_fetch_unit;
  localparam int AW = 12;
  localparam int WW = 16;
  localparam int D  = 4;

`ifdef FETCH_PARITY_EN
  localparam logic EXP_PAR_8001 = 1'b1;
`else
  localparam logic EXP_PAR_8001 = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_addr;
  logic          pc_enable;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [WW-1:0] mem_rdata;
  logic          flush;
  logic          instr_valid;
  logic          instr_ready;
  logic [14:0]   instr_word;
  logic [AW-1:0] instr_addr;
  logic          instr_parity_err;

  int checks   = 0;
  int failures = 0;

  // Bench-side PC and memory model state
  logic [AW-1:0] pc;
  int            lat;
  logic          mem_accept;
  logic          pv [4];
  logic [AW-1:0] pa [4];
  logic          last_pc_en;
  logic [AW-1:0] last_mem_addr;
  logic [AW-1:0] exp_q [$];

  fetch_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_addr          (pc_addr),
    .pc_enable        (pc_enable),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .flush            (flush),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_word       (instr_word),
    .instr_addr       (instr_addr),
    .instr_parity_err (instr_parity_err)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: two fixed parity probes, a regular pattern elsewhere
  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (a == 12'h100) return 16'h8001;
    if (a == 12'h101) return 16'h0001;
    return {a[0], 3'b101, a};
  endfunction

  // One clock cycle.
  // Sample the request at the negedge, then let the edge happen.
  // After the edge, advance the PC and memory models.
  task automatic step();
    logic          req;
    logic [AW-1:0] a;
    @(negedge clk);
    req           = mem_req;
    a             = mem_addr;
    last_pc_en    = pc_enable;
    last_mem_addr = mem_addr;
    @(posedge clk);
    #1;
    if (req) pc = pc + 1'b1;
    pc_addr = pc;
    for (int k = 0; k < 3; k++) begin
      pv[k] = pv[k+1];
      pa[k] = pa[k+1];
    end
    pv[3] = 1'b0;
    pa[3] = '0;
    if (req && mem_accept) begin
      pv[lat-1] = 1'b1;
      pa[lat-1] = a;
    end
    mem_rvalid = pv[0];
    mem_rdata  = pv[0] ? mem_word(pa[0]) : '0;
  endtask

  task automatic apply_reset(input logic [AW-1:0] base);
    reset       = 1'b1;
    flush       = 1'b0;
    instr_ready = 1'b0;
    mem_accept  = 1'b1;
    lat         = 1;
    for (int k = 0; k < 4; k++) begin
      pv[k] = 1'b0;
      pa[k] = '0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    pc         = base;
    pc_addr    = base;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(12'h000);
    reset = 1'b1;
    #1;
    checks++;
    if (last_pc_en !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: pc_en=%b mem_req=%b expected 0", last_pc_en, mem_req);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0", instr_valid);
    end
    checks++;
    if (instr_word !== 15'h0000 || instr_addr !== 12'h000) begin
      failures++;
      $display("FAIL reset_data: word=%h addr=%h expected 0", instr_word, instr_addr);
    end
    checks++;
    if (instr_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_parity: got %b expected 0", instr_parity_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pc_enable !== 1'b1 || mem_addr !== 12'h000) begin
      failures++;
      $display("FAIL reset_release: pc_en=%b addr=%h expected 1/000", pc_enable, mem_addr);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] e;
    apply_reset(12'h000);
    instr_ready = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(AW'(k));
      step();
      checks++;
      if (last_pc_en !== 1'b1 || last_mem_addr !== AW'(k)) begin
        failures++;
        $display("FAIL stream_issue[%0d]: pc_en=%b addr=%h expected 1/%h", k, last_pc_en, last_mem_addr, AW'(k));
      end
      if (k == 0) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_latency: valid=%b expected 0 after first edge", instr_valid);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== e || instr_word !== {3'b101, e}) begin
          failures++;
          $display("FAIL stream_word[%0d]: valid=%b addr=%h word=%h expected 1/%h/%h", k, instr_valid, instr_addr, instr_word, e, {3'b101, e});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int issues;
    apply_reset(12'h000);
    issues = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (last_pc_en) issues++;
    end
    checks++;
    if (issues != 4 || last_pc_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_issues: issues=%0d pc_en=%b expected 4/0", issues, last_pc_en);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h000) begin
      failures++;
      $display("FAIL bp_head: valid=%b addr=%h expected 1/000", instr_valid, instr_addr);
    end
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== AW'(j) || instr_word !== {3'b101, AW'(j)}) begin
        failures++;
        $display("FAIL bp_pop[%0d]: valid=%b addr=%h word=%h expected 1/%h", j, instr_valid, instr_addr, instr_word, AW'(j));
      end
      step();
      if (j == 1) begin
        checks++;
        if (last_pc_en !== 1'b1) begin
          failures++;
          $display("FAIL bp_resume: pc_en=%b expected 1", last_pc_en);
        end
      end
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h004) begin
      failures++;
      $display("FAIL bp_after: valid=%b addr=%h expected 1/004", instr_valid, instr_addr);
    end
  endtask

  task automatic test_back_to_back();
    int issues;
    apply_reset(12'h000);
    for (int k = 0; k < 4; k++) step();
    // One pop on the same edge as the last response arrives
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (last_pc_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_credit: pc_en=%b expected 0", last_pc_en);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h001) begin
      failures++;
      $display("FAIL b2b_head: valid=%b addr=%h expected 1/001", instr_valid, instr_addr);
    end
    // Count held at 3 after push+pop leaves room for exactly one more read.
    issues = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_pc_en) issues++;
    end
    checks++;
    if (issues != 1) begin
      failures++;
      $display("FAIL b2b_refill: issues=%0d expected 1", issues);
    end
    instr_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== AW'(j)) begin
        failures++;
        $display("FAIL b2b_order[%0d]: valid=%b addr=%h expected 1/%h", j, instr_valid, instr_addr, AW'(j));
      end
      step();
    end
  endtask

  task automatic test_flush_latency();
    apply_reset(12'h000);
    lat         = 3;
    instr_ready = 1'b1;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (last_pc_en !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle: pc_en=%b valid=%b expected 0/0", last_pc_en, instr_valid);
    end
    step();
    checks++;
    if (last_pc_en !== 1'b1 || last_mem_addr !== 12'h002) begin
      failures++;
      $display("FAIL flush_resume: pc_en=%b addr=%h expected 1/002", last_pc_en, last_mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_drop[%0d]: valid=%b addr=%h expected 0", k, instr_valid, instr_addr);
      end
      step();
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h002 || instr_word !== {3'b101, 12'h002}) begin
      failures++;
      $display("FAIL flush_next: valid=%b addr=%h word=%h expected 1/002/%h", instr_valid, instr_addr, instr_word, {3'b101, 12'h002});
    end
  endtask

  task automatic test_flush_buffered();
    apply_reset(12'h000);
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h000) begin
      failures++;
      $display("FAIL fbuf_head: valid=%b addr=%h expected 1/000", instr_valid, instr_addr);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (last_pc_en !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL fbuf_flush: pc_en=%b valid=%b expected 0/0", last_pc_en, instr_valid);
    end
    step();
    checks++;
    if (last_mem_addr !== 12'h003 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL fbuf_issue: addr=%h valid=%b expected 003/0", last_mem_addr, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h003) begin
      failures++;
      $display("FAIL fbuf_next: valid=%b addr=%h expected 1/003", instr_valid, instr_addr);
    end
  endtask

  task automatic test_parity();
    apply_reset(12'h100);
    instr_ready = 1'b1;
    step();
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h100 || instr_word !== 15'h0001 || instr_parity_err !== EXP_PAR_8001) begin
      failures++;
      $display("FAIL parity_8001: valid=%b addr=%h word=%h perr=%b expected 1/100/0001/%b", instr_valid, instr_addr, instr_word, instr_parity_err, EXP_PAR_8001);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h101 || instr_word !== 15'h0001 || instr_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_0001: valid=%b addr=%h word=%h perr=%b expected 1/101/0001/0", instr_valid, instr_addr, instr_word, instr_parity_err);
    end
  endtask

  task automatic test_reset_midflight();
    int issues;
    apply_reset(12'h000);
    lat = 3;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 12'h000) begin
      failures++;
      $display("FAIL mid_pre: valid=%b addr=%h expected 1/000", instr_valid, instr_addr);
    end
    mem_accept = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (last_pc_en !== 1'b0 || instr_valid !== 1'b0 || instr_word !== 15'h0000 || instr_addr !== 12'h000 || instr_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: pc_en=%b valid=%b word=%h addr=%h perr=%b expected all 0", last_pc_en, instr_valid, instr_word, instr_addr, instr_parity_err);
    end
    // The late response to the last pre-reset read arrives in this cycle.
    issues = 0;
    step();
    if (last_pc_en) issues++;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_stray: valid=%b expected 0", instr_valid);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (last_pc_en) issues++;
    end
    checks++;
    if (issues != 4 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_credit: issues=%0d valid=%b expected 4/0", issues, instr_valid);
    end
  endtask

  // Test sequence and final report
  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    instr_ready = 1'b0;
    pc_addr     = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush_latency();
    test_flush_buffered();
    test_parity();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
